// File: rtl/mips_alu.sv
// -----------------------------------------------------------------------------
// mips_alu : 32-bit MIPS integer ALU for the EXE pipeline stage.
//
// Produces a combinational result from two operands, a 6-bit operation code
// and a 5-bit shift amount. Owns the architectural HI/LO registers, written on
// the rising CLOCK edge by MTHI/MTLO/MULT/MULTU/DIV/DIVU (single cycle).
//
// Ports:
//   CLOCK          in   1   rising-edge clock for HI/LO
//   RESET          in   1   asynchronous, active-low reset of HI/LO
//   OperandA_IN    in  32   rs-side operand
//   OperandB_IN    in  32   rt-side operand (or immediate)
//   ALUControl_IN  in   6   operation select
//   ShiftAmount_IN in   5   shamt for constant shifts
//   ALUResult_OUT  out 32   combinational result
//   HI_OUT         out 32   registered HI
//   LO_OUT         out 32   registered LO
//   Overflow_OUT   out  1   signed overflow of ADD/SUB (only with the macro)
//
// Optional feature macro: ALU_OVERFLOW_EN (adds Overflow_OUT).
// -----------------------------------------------------------------------------
module mips_alu (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] OperandA_IN,
    input  logic [31:0] OperandB_IN,
    input  logic [5:0]  ALUControl_IN,
    input  logic [4:0]  ShiftAmount_IN,
    output logic [31:0] ALUResult_OUT,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT
`ifdef ALU_OVERFLOW_EN
    ,
    output logic        Overflow_OUT
`endif
);

    localparam logic [5:0] OP_SLL   = 6'h00;
    localparam logic [5:0] OP_SRL   = 6'h02;
    localparam logic [5:0] OP_SRA   = 6'h03;
    localparam logic [5:0] OP_SLLV  = 6'h04;
    localparam logic [5:0] OP_SRLV  = 6'h06;
    localparam logic [5:0] OP_SRAV  = 6'h07;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;
    localparam logic [5:0] OP_ADD   = 6'h20;
    localparam logic [5:0] OP_ADDU  = 6'h21;
    localparam logic [5:0] OP_SUB   = 6'h22;
    localparam logic [5:0] OP_SUBU  = 6'h23;
    localparam logic [5:0] OP_AND   = 6'h24;
    localparam logic [5:0] OP_OR    = 6'h25;
    localparam logic [5:0] OP_XOR   = 6'h26;
    localparam logic [5:0] OP_NOR   = 6'h27;
    localparam logic [5:0] OP_SLT   = 6'h2A;
    localparam logic [5:0] OP_SLTU  = 6'h2B;

    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic        div_signed_s;
    logic        div_by_zero_s;
    logic [31:0] num_mag_s;
    logic [31:0] den_mag_s;
    logic [31:0] quot_mag_s;
    logic [31:0] rem_mag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    assign sum_s  = OperandA_IN + OperandB_IN;
    assign diff_s = OperandA_IN - OperandB_IN;

    // Sign-extending to 64 bits makes the low 64 bits of the product the
    // correct two's-complement result.
    assign prod_signed_s   = {{32{OperandA_IN[31]}}, OperandA_IN} * {{32{OperandB_IN[31]}}, OperandB_IN};
    assign prod_unsigned_s = {32'd0, OperandA_IN} * {32'd0, OperandB_IN};

    assign div_by_zero_s = (OperandB_IN == 32'd0);

    // Shared unsigned divider on operand magnitudes; signs are restored after.
    always_comb begin
        div_signed_s = (ALUControl_IN == OP_DIV);
        if (div_signed_s && OperandA_IN[31]) begin
            num_mag_s = 32'd0 - OperandA_IN;
        end else begin
            num_mag_s = OperandA_IN;
        end
        if (div_signed_s && OperandB_IN[31]) begin
            den_mag_s = 32'd0 - OperandB_IN;
        end else begin
            den_mag_s = OperandB_IN;
        end
        // A zero divisor never commits; substitute 1 to keep the divider defined.
        if (den_mag_s == 32'd0) begin
            quot_mag_s = num_mag_s;
            rem_mag_s  = 32'd0;
        end else begin
            quot_mag_s = num_mag_s / den_mag_s;
            rem_mag_s  = num_mag_s % den_mag_s;
        end
        // Quotient truncates toward zero; remainder takes the dividend's sign.
        // 0x80000000 / -1 wraps naturally to quotient 0x80000000, remainder 0.
        if (div_signed_s && (OperandA_IN[31] ^ OperandB_IN[31])) begin
            quot_s = 32'd0 - quot_mag_s;
        end else begin
            quot_s = quot_mag_s;
        end
        if (div_signed_s && OperandA_IN[31]) begin
            rem_s = 32'd0 - rem_mag_s;
        end else begin
            rem_s = rem_mag_s;
        end
    end

    // Combinational result select; HI/LO reads see only the registered value.
    always_comb begin
        ALUResult_OUT = 32'd0;
        case (ALUControl_IN)
            OP_ADD, OP_ADDU: ALUResult_OUT = sum_s;
            OP_SUB, OP_SUBU: ALUResult_OUT = diff_s;
            OP_AND:          ALUResult_OUT = OperandA_IN & OperandB_IN;
            OP_OR:           ALUResult_OUT = OperandA_IN | OperandB_IN;
            OP_XOR:          ALUResult_OUT = OperandA_IN ^ OperandB_IN;
            OP_NOR:          ALUResult_OUT = ~(OperandA_IN | OperandB_IN);
            OP_SLT:          ALUResult_OUT = {31'd0, ($signed(OperandA_IN) < $signed(OperandB_IN))};
            OP_SLTU:         ALUResult_OUT = {31'd0, (OperandA_IN < OperandB_IN)};
            OP_SLL:          ALUResult_OUT = OperandB_IN << ShiftAmount_IN;
            OP_SRL:          ALUResult_OUT = OperandB_IN >> ShiftAmount_IN;
            OP_SRA:          ALUResult_OUT = $unsigned($signed(OperandB_IN) >>> ShiftAmount_IN);
            OP_SLLV:         ALUResult_OUT = OperandB_IN << OperandA_IN[4:0];
            OP_SRLV:         ALUResult_OUT = OperandB_IN >> OperandA_IN[4:0];
            OP_SRAV:         ALUResult_OUT = $unsigned($signed(OperandB_IN) >>> OperandA_IN[4:0]);
            OP_LUI:          ALUResult_OUT = {OperandB_IN[15:0], 16'h0000};
            OP_MFHI:         ALUResult_OUT = hi_r;
            OP_MFLO:         ALUResult_OUT = lo_r;
            default:         ALUResult_OUT = 32'd0;
        endcase
    end

    // HI/LO architectural registers; divide by zero leaves both untouched.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            case (ALUControl_IN)
                OP_MTHI: hi_r <= OperandA_IN;
                OP_MTLO: lo_r <= OperandA_IN;
                OP_MULT: begin
                    hi_r <= prod_signed_s[63:32];
                    lo_r <= prod_signed_s[31:0];
                end
                OP_MULTU: begin
                    hi_r <= prod_unsigned_s[63:32];
                    lo_r <= prod_unsigned_s[31:0];
                end
                OP_DIV, OP_DIVU: begin
                    if (!div_by_zero_s) begin
                        hi_r <= rem_s;
                        lo_r <= quot_s;
                    end else begin
                        hi_r <= hi_r;
                        lo_r <= lo_r;
                    end
                end
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end
    end

    assign HI_OUT = hi_r;
    assign LO_OUT = lo_r;

`ifdef ALU_OVERFLOW_EN
    // Signed overflow flag; the result itself still wraps.
    always_comb begin
        Overflow_OUT = 1'b0;
        case (ALUControl_IN)
            OP_ADD:  Overflow_OUT = (OperandA_IN[31] == OperandB_IN[31]) && (sum_s[31] != OperandA_IN[31]);
            OP_SUB:  Overflow_OUT = (OperandA_IN[31] != OperandB_IN[31]) && (diff_s[31] != OperandA_IN[31]);
            default: Overflow_OUT = 1'b0;
        endcase
    end
`endif

endmodule

// File: tb/tb_mips_alu.sv
// -----------------------------------------------------------------------------
// tb_mips_alu : directed-vector scoreboard bench for mips_alu.
// Each vector carries hand-computed result/HI/LO values as seen at the falling
// edge of its cycle (HI/LO reflect all earlier cycles' ops, not this one).
// -----------------------------------------------------------------------------
module tb_mips_alu;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
        logic [1:0]  rstm;   // 1: pull reset low mid-cycle, 2: release reset at drive
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } exp_t;

    logic        clk_s;
    logic        rst_n_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [5:0]  op_s;
    logic [4:0]  sh_s;
    logic [31:0] res_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;
`ifdef ALU_OVERFLOW_EN
    logic        ovf_s;
`endif
    logic        vld_s;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;

    mips_alu dut (
        .CLOCK          (clk_s),
        .RESET          (rst_n_s),
        .OperandA_IN    (a_s),
        .OperandB_IN    (b_s),
        .ALUControl_IN  (op_s),
        .ShiftAmount_IN (sh_s),
        .ALUResult_OUT  (res_s),
        .HI_OUT         (hi_s),
`ifdef ALU_OVERFLOW_EN
        .LO_OUT         (lo_s),
        .Overflow_OUT   (ovf_s)
`else
        .LO_OUT         (lo_s)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    function automatic void add(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [31:0] res, input logic [31:0] hi,
                                input logic [31:0] lo, input logic ovf, input logic [1:0] rstm);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res;
        v.hi = hi; v.lo = lo; v.ovf = ovf; v.rstm = rstm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %08h expected %08h", id, name, got, exp);
        end
    endtask

    // Monitor: pop one expectation per presented vector at the falling edge.
    always @(negedge clk_s) begin
        exp_t e;
        if (vld_s) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: got output with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                check("result", e.id, res_s, e.res);
                check("hi", e.id, hi_s, e.hi);
                check("lo", e.id, lo_s, e.lo);
`ifdef ALU_OVERFLOW_EN
                check("overflow", e.id, {31'd0, ovf_s}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Stimulus: drive one vector per cycle just after the rising edge.
    initial begin
        exp_t e;
        n_cmp   = 0;
        n_err   = 0;
        vld_s   = 1'b0;
        rst_n_s = 1'b0;
        a_s     = 32'd0;
        b_s     = 32'd0;
        op_s    = 6'h00;
        sh_s    = 5'd0;

        //   op     A             B             sh     result        HI            LO            ovf   rstm
        add(6'h00, 32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // reset state
        add(6'h20, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 2'd2); // ADD wraps
        add(6'h21, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // ADDU
        add(6'h23, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SUBU
        add(6'h22, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 2'd0); // SUB wraps
        add(6'h27, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // NOR
        add(6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // AND
        add(6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // OR
        add(6'h26, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // XOR
        add(6'h2A, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SLT
        add(6'h2B, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SLTU
        add(6'h03, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SRA
        add(6'h02, 32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SRL
        add(6'h00, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SLL
        add(6'h06, 32'h00000024, 32'h80000000, 5'd0,  32'h08000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SRLV A[4:0]=4
        add(6'h07, 32'hFFFFFFE1, 32'h80000000, 5'd9,  32'hC0000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SRAV A[4:0]=1
        add(6'h04, 32'h00000020, 32'h12345678, 5'd3,  32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // SLLV A[4:0]=0
        add(6'h0F, 32'hFFFFFFFF, 32'h00001234, 5'd0,  32'h12340000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // LUI
        add(6'h18, 32'hFFFFFFFE, 32'h00000003, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // MULT
        add(6'h10, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 2'd0); // MFHI after MULT
        add(6'h19, 32'hFFFFFFFE, 32'h00000003, 5'd0,  32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 2'd0); // MULTU
        add(6'h12, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFA, 1'b0, 2'd0); // MFLO after MULTU
        add(6'h1A, 32'hFFFFFFF9, 32'h00000002, 5'd0,  32'h00000000, 32'h00000002, 32'hFFFFFFFA, 1'b0, 2'd0); // DIV -7/2
        add(6'h1B, 32'h00000007, 32'h00000000, 5'd0,  32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 2'd0); // DIVU by zero
        add(6'h1A, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 2'd0); // DIV min/-1
        add(6'h1B, 32'h00000064, 32'h00000007, 5'd0,  32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 2'd0); // DIVU 100/7
        add(6'h11, 32'hDEADBEEF, 32'h00000000, 5'd0,  32'h00000000, 32'h00000002, 32'h0000000E, 1'b0, 2'd0); // MTHI, old HI visible
        add(6'h10, 32'h00000000, 32'h00000000, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0000000E, 1'b0, 2'd0); // MFHI new
        add(6'h13, 32'hCAFEF00D, 32'h00000000, 5'd0,  32'h00000000, 32'hDEADBEEF, 32'h0000000E, 1'b0, 2'd0); // MTLO
        add(6'h12, 32'h00000000, 32'h00000000, 5'd0,  32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 2'd0); // MFLO new
        add(6'h3F, 32'h00000001, 32'h00000001, 5'd0,  32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 2'd0); // unused code
        add(6'h2C, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 2'd0); // unused code holds
        add(6'h18, 32'h00000005, 32'h00000007, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2'd1); // reset with MULT pending
        add(6'h10, 32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2'd2); // MFHI after reset
        add(6'h12, 32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2'd0); // MFLO after reset

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk_s);
            #1;
            if (vecs[i].rstm == 2'd2) rst_n_s = 1'b1;
            op_s = vecs[i].op;
            a_s  = vecs[i].a;
            b_s  = vecs[i].b;
            sh_s = vecs[i].sh;
            e.id  = i;
            e.res = vecs[i].res;
            e.hi  = vecs[i].hi;
            e.lo  = vecs[i].lo;
            e.ovf = vecs[i].ovf;
            exp_q.push_back(e);
            vld_s = 1'b1;
            if (vecs[i].rstm == 2'd1) begin
                #1;
                rst_n_s = 1'b0;
            end
        end
        @(posedge clk_s);
        #1;
        vld_s = 1'b0;
        op_s  = 6'h00;
        repeat (2) @(posedge clk_s);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d expectations left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
